// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory arbiter      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [7:0] C_IF_RMASK = 8'hff;

endpackage
`default_nettype wire

// File: rtl/mem_arb_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_sel : LS-priority grant with a streak limit protecting IF    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_arb_sel #(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic idle,
  input  logic accept,
  output logic grant_ls,
  output logic grant_if
);

  localparam logic [3:0] C_MAX_STREAK = 4'(MAX_LS_STREAK);

  logic [3:0] r_streak;
  logic       w_force_if;

  // Once LS has won MAX_LS_STREAK times against a waiting IF, IF takes the next slot.
  assign w_force_if = if_valid && (r_streak == C_MAX_STREAK);
  assign grant_ls   = idle && ls_valid && !w_force_if;
  assign grant_if   = idle && if_valid && !grant_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= 4'd0;
    end else if (accept) begin
      if (grant_if) begin
        r_streak <= 4'd0;
      end else if (grant_ls && if_valid && (r_streak != C_MAX_STREAK)) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : shares one memory port between IF and LS requesters    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic [63:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_addr,
  input  logic        ls_wen,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_resp_valid,
  output logic [63:0] ls_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata
);

  import mem_arb_pkg::*;

  state_t      r_state;
  owner_t      r_owner;
  logic        r_req_valid;
  logic [63:0] r_addr;
  logic        r_wen;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;

  logic w_idle;
  logic w_in_wait;
  logic w_grant_if;
  logic w_grant_ls;
  logic w_accept;

  assign w_idle    = (r_state == IDLE);
  assign w_in_wait = (r_state == WAIT);

  mem_arb_sel #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .idle     (w_idle),
    .accept   (w_accept),
    .grant_ls (w_grant_ls),
    .grant_if (w_grant_if)
  );

  // Grants already include the requester's valid, so any grant is an accept.
  assign w_accept     = w_grant_if | w_grant_ls;
  assign if_req_ready = w_grant_if;
  assign ls_req_ready = w_grant_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_req_valid <= 1'b0;
      r_addr      <= 64'd0;
      r_wen       <= 1'b0;
      r_wdata     <= 64'd0;
      r_wmask     <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= REQ;
            r_req_valid <= 1'b1;
            if (w_grant_ls) begin
              r_owner <= OWN_LS;
              r_addr  <= ls_addr;
              r_wen   <= ls_wen;
              r_wdata <= ls_wdata;
              r_wmask <= ls_wmask;
            end else begin
              r_owner <= OWN_IF;
              r_addr  <= if_addr;
              r_wen   <= 1'b0;
              r_wdata <= 64'd0;
              r_wmask <= C_IF_RMASK;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_state     <= WAIT;
            r_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

  // Responses outside WAIT (including one coincident with the handshake) are stray.
  assign if_resp_valid = mem_resp_valid && w_in_wait && (r_owner == OWN_IF);
  assign ls_resp_valid = mem_resp_valid && w_in_wait && (r_owner == OWN_LS);
  assign if_rdata      = mem_rdata;
  assign ls_rdata      = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : self-checking bench for mem_arbiter                 |
// | Revision       : 1.0 - initial release                               |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = 64'd0;
  logic        if_resp_valid;
  logic [63:0] if_rdata;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic [63:0] ls_addr = 64'd0;
  logic        ls_wen = 1'b0;
  logic [63:0] ls_wdata = 64'd0;
  logic [7:0]  ls_wmask = 8'd0;
  logic        ls_resp_valid;
  logic [63:0] ls_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_LS_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          is_ls;
    bit          wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    bit          is_ls;
    bit          wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          stall;
    int          lat;
    bit          exp_wen;
    logic [7:0]  exp_wmask;
  } vec_t;

  exp_t sb_q[$];
  exp_t cur;
  bit   have_pl = 0;
  bit   hs_done = 0;
  bit   acc_log[$];
  int   pulses = 0;
  int   checks = 0;
  int   errors = 0;

  // memory model state
  bit          auto_mem = 0;
  int          stall_cfg = 0, lat_cfg = 1, stall_left = 0, lat_left = 0;
  bit          pend = 0;
  logic [63:0] rdata_cfg = 64'd0;
  bit          s_hs = 0, s_resp = 0, s_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    bit   exp_pulse;
    bit   acc_if, acc_ls;
    exp_t e;
    s_hs    = mem_req_valid && mem_req_ready;
    s_stall = mem_req_valid && !mem_req_ready;
    s_resp  = mem_resp_valid;
    chk("mem_req_valid", {63'd0, mem_req_valid}, {63'd0, have_pl && !hs_done});
    if (have_pl) begin
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wen", {63'd0, mem_wen}, {63'd0, cur.wen});
      chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, cur.wmask});
      if (cur.wen) chk("mem_wdata", mem_wdata, cur.wdata);
    end
    exp_pulse = have_pl && hs_done && s_resp;
    chk("resp_pulse", {62'd0, if_resp_valid, ls_resp_valid},
        exp_pulse ? (cur.is_ls ? 64'd1 : 64'd2) : 64'd0);
    if (exp_pulse) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd0, 64'd1);
      end else begin
        e = sb_q.pop_front();
        chk("resp_rdata", e.is_ls ? ls_rdata : if_rdata, e.rdata);
      end
      have_pl = 0;
      hs_done = 0;
      pulses++;
    end
    if (have_pl && s_hs) hs_done = 1;
    if (rst_n) begin
      chk("ready_onehot", {63'd0, if_req_ready && ls_req_ready}, 64'd0);
      if (have_pl) chk("ready_busy", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
      acc_if = if_req_valid && if_req_ready;
      acc_ls = ls_req_valid && ls_req_ready;
      if (acc_if || acc_ls) begin
        cur.is_ls = acc_ls;
        cur.wen   = acc_ls ? ls_wen : 1'b0;
        cur.addr  = acc_ls ? ls_addr : if_addr;
        cur.wdata = ls_wdata;
        cur.wmask = acc_ls ? ls_wmask : 8'hff;
        cur.rdata = rdata_cfg;
        sb_q.push_back(cur);
        have_pl = 1;
        hs_done = 0;
        acc_log.push_back(acc_ls);
      end
    end
  endtask

  task automatic drive_mem();
    if (!auto_mem) return;
    if (s_resp) pend = 0;
    if (s_hs) begin
      pend       = 1;
      lat_left   = lat_cfg;
      stall_left = stall_cfg;
    end else if (s_stall && stall_left > 0) begin
      stall_left--;
    end
    mem_req_ready  = (stall_left == 0);
    mem_resp_valid = 1'b0;
    if (pend) begin
      lat_left--;
      mem_resp_valid = (lat_left == 0);
    end
    mem_rdata = rdata_cfg;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic clear_model();
    auto_mem = 0; pend = 0; have_pl = 0; hs_done = 0;
    s_hs = 0; s_resp = 0; s_stall = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req_valid = 0; ls_req_valid = 0;
    mem_req_ready = 0; mem_resp_valid = 0;
    clear_model();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  vec_t vecs[5];
  int   n, p;

  initial begin
    vecs[0] = '{0, 0, 64'h8000_0000, 64'd0, 8'h00, 64'h0010_0073, 0, 2, 0, 8'hff};
    vecs[1] = '{1, 1, 64'h8000_1000, 64'hdead_beef, 8'h0f, 64'h0, 5, 1, 1, 8'h0f};
    vecs[2] = '{1, 0, 64'h8000_2008, 64'd0, 8'hff, 64'hcafe_f00d_1234_5678, 0, 1, 0, 8'hff};
    vecs[3] = '{0, 0, 64'h8000_0004, 64'd0, 8'h00, 64'h0000_0513, 2, 3, 0, 8'hff};
    vecs[4] = '{1, 1, 64'h0000_0ff8, 64'h0102_0304_0506_0708, 8'h80, 64'h0, 1, 4, 1, 8'h80};

    // reset values
    #1;
    chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wmask", {56'd0, mem_wmask}, 64'd0);
    do_reset();

    foreach (vecs[i]) begin
      auto_mem   = 1;
      stall_cfg  = vecs[i].stall;
      stall_left = vecs[i].stall;
      lat_cfg    = vecs[i].lat;
      rdata_cfg  = vecs[i].rdata;
      if (vecs[i].is_ls) begin
        ls_req_valid = 1; ls_addr = vecs[i].addr; ls_wen = vecs[i].wen;
        ls_wdata = vecs[i].wdata; ls_wmask = vecs[i].wmask;
      end else begin
        if_req_valid = 1; if_addr = vecs[i].addr;
      end
      n = acc_log.size();
      for (int c = 0; c < 20 && acc_log.size() == n; c++) tick();
      if_req_valid = 0;
      ls_req_valid = 0;
      if (acc_log.size() == n) begin
        chk("tbl_accept_timeout", 64'd0, 64'd1);
      end else begin
        chk("tbl_winner", {63'd0, acc_log[acc_log.size()-1]}, {63'd0, vecs[i].is_ls});
        chk("tbl_wen", {63'd0, mem_wen}, {63'd0, vecs[i].exp_wen});
        chk("tbl_wmask", {56'd0, mem_wmask}, {56'd0, vecs[i].exp_wmask});
        chk("tbl_addr", mem_addr, vecs[i].addr);
      end
      p = pulses;
      for (int c = 0; c < 40 && pulses == p; c++) tick();
      repeat (2) tick();
      chk("tbl_resp_count", 64'(pulses - p), 64'd1);
    end

    // stray response while idle, then same-cycle response at the handshake
    auto_mem = 0; pend = 0;
    mem_req_ready = 0; mem_resp_valid = 1; rdata_cfg = 64'h55aa; mem_rdata = 64'h55aa;
    p = pulses;
    repeat (2) tick();
    mem_resp_valid = 0;
    chk("stray_idle_pulses", 64'(pulses - p), 64'd0);
    if_req_valid = 1; if_addr = 64'h8000_0100;
    n = acc_log.size();
    tick();
    if_req_valid = 0;
    chk("stray_idle_accept", 64'(acc_log.size() - n), 64'd1);
    mem_req_ready = 1; mem_resp_valid = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 0;
    repeat (2) tick();
    chk("same_cycle_ignored", 64'(pulses - p), 64'd0);
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    tick();
    chk("late_resp", 64'(pulses - p), 64'd1);

    // reset in the middle of WAIT
    auto_mem = 1; stall_cfg = 0; stall_left = 0; lat_cfg = 20; rdata_cfg = 64'h77;
    ls_req_valid = 1; ls_addr = 64'h8000_3000; ls_wen = 0; ls_wmask = 8'hff;
    n = acc_log.size();
    for (int c = 0; c < 20 && acc_log.size() == n; c++) tick();
    ls_req_valid = 0;
    repeat (4) tick();
    chk("pre_rst_in_wait", {63'd0, hs_done}, 64'd1);
    auto_mem = 0;
    mem_rdata = 64'h1234_5678;
    mem_resp_valid = 1;
    ls_req_valid = 1;
    rst_n = 0;
    #1;
    chk("rst_async_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_async_addr", mem_addr, 64'd0);
    chk("rst_async_wen", {63'd0, mem_wen}, 64'd0);
    chk("rst_async_wdata", mem_wdata, 64'd0);
    chk("rst_async_wmask", {56'd0, mem_wmask}, 64'd0);
    chk("rst_async_ls_resp", {63'd0, ls_resp_valid}, 64'd0);
    chk("rst_async_if_resp", {63'd0, if_resp_valid}, 64'd0);
    chk("rst_ls_rdata", ls_rdata, 64'h1234_5678);
    chk("rst_ls_ready", {62'd0, if_req_ready, ls_req_ready}, 64'd1);
    ls_req_valid = 0;
    clear_model();
    p = pulses;
    tick();
    rst_n = 1;
    repeat (2) tick();
    mem_resp_valid = 0;
    tick();
    chk("rst_later_resp", 64'(pulses - p), 64'd0);

    // both requesters valid continuously: LS x4 then IF, repeated
    do_reset();
    auto_mem = 1; stall_cfg = 0; stall_left = 0; lat_cfg = 1; rdata_cfg = 64'h99;
    if_req_valid = 1; if_addr = 64'h8000_0200;
    ls_req_valid = 1; ls_addr = 64'h8000_4000; ls_wen = 0; ls_wmask = 8'hff;
    acc_log.delete();
    for (int c = 0; c < 200 && acc_log.size() < 10; c++) tick();
    if_req_valid = 0;
    ls_req_valid = 0;
    for (int c = 0; c < 20 && have_pl; c++) tick();
    if (acc_log.size() < 10) begin
      chk("streak_timeout", 64'(acc_log.size()), 64'd10);
    end else begin
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("streak_grant%0d", i), {63'd0, acc_log[i]}, {63'd0, (i % 5) != 4});
      end
    end
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
